// File: rtl/pe_tile_scheduler.sv
// rtl/pe_tile_scheduler.sv - tile batch sequencer: buffer fetch/unpack, PE load/compute handshake, result writeback
// Optional busy-cycle counter enabled by defining PE_TILE_SCHED_PERF_EN.
module pe_tile_scheduler #(
    parameter int ARRAY_SIZE             = 8,
    parameter int COMPUTE_DATA_WIDTH     = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int BUFFER_WORD_SIZE       = 16,
    parameter int NUM_COMPUTE_LANES      = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
    parameter int ADDR_WIDTH             = 12,
    parameter int TILE_CNT_WIDTH         = 8
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    cmd_valid,
    output logic                                                    cmd_ready,
    input  logic [TILE_CNT_WIDTH-1:0]                               cmd_num_tiles,
    input  logic                                                    cmd_reuse_w,
    input  logic [ADDR_WIDTH-1:0]                                   cmd_w_base,
    input  logic [ADDR_WIDTH-1:0]                                   cmd_d_base,
    input  logic [ADDR_WIDTH-1:0]                                   cmd_r_base,
    output logic                                                    rd_en,
    output logic [ADDR_WIDTH-1:0]                                   rd_addr,
    input  logic [BUFFER_WORD_SIZE-1:0]                             rd_data,
    output logic                                                    wr_valid,
    input  logic                                                    wr_ready,
    output logic [ADDR_WIDTH-1:0]                                   wr_addr,
    output logic [BUFFER_WORD_SIZE-1:0]                             wr_data,
    output logic                                                    pe_load_en,
    output logic                                                    pe_compute,
    input  logic                                                    pe_done,
    output logic [COMPUTE_DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]     pe_datas,
    output logic [COMPUTE_DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]     pe_weights,
    input  logic [ACCUMULATOR_DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] pe_results,
    output logic                                                    busy,
    output logic                                                    batch_done,
    output logic [31:0]                                             perf_cycles
);
    localparam int ELEMS = ARRAY_SIZE * ARRAY_SIZE;
    localparam int W     = ELEMS / NUM_COMPUTE_LANES;
    localparam int CNT_W = $clog2(ELEMS + 1);
    localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(W);
    localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] LAST_EL  = CNT_W'(ELEMS - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, ARM, COMPUTE, WRITEBACK, FINISH} state_t;

    state_t                                          state;
    logic [CNT_W-1:0]                                cnt;
    logic [TILE_CNT_WIDTH-1:0]                       t;
    logic [TILE_CNT_WIDTH-1:0]                       num_tiles;
    logic                                            reuse_w;
    logic [ADDR_WIDTH-1:0]                           w_base;
    logic [ADDR_WIDTH-1:0]                           d_base;
    logic [ADDR_WIDTH-1:0]                           r_base;
    logic [ACCUMULATOR_DATA_WIDTH*ELEMS-1:0]         snap;
    logic [TILE_CNT_WIDTH-1:0]                       next_t;

    assign next_t    = t + TILE_CNT_WIDTH'(1);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Offsets wrap modulo the address space.
    function automatic logic [ADDR_WIDTH-1:0] tile_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [TILE_CNT_WIDTH-1:0] tile,
                                                        input int stride);
        logic [31:0] off;
        off = 32'(tile) * 32'(stride);
        return base + off[ADDR_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            t          <= '0;
            num_tiles  <= '0;
            reuse_w    <= 1'b0;
            w_base     <= '0;
            d_base     <= '0;
            r_base     <= '0;
            snap       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            pe_load_en <= 1'b0;
            pe_compute <= 1'b0;
            pe_datas   <= '0;
            pe_weights <= '0;
            batch_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    num_tiles <= cmd_num_tiles;
                    reuse_w   <= cmd_reuse_w;
                    w_base    <= cmd_w_base;
                    d_base    <= cmd_d_base;
                    r_base    <= cmd_r_base;
                    t         <= '0;
                    cnt       <= '0;
                    if (cmd_num_tiles == '0) begin
                        state      <= FINISH;
                        batch_done <= 1'b1;
                    end else begin
                        state   <= LOAD_W;
                        rd_en   <= 1'b1;
                        rd_addr <= cmd_w_base;
                    end
                end
                LOAD_W, LOAD_D: begin
                    // Read data lags its strobe by one cycle, so word cnt-1 lands now.
                    if (cnt != '0) begin
                        if (state == LOAD_W)
                            pe_weights[(int'(cnt) - 1) * BUFFER_WORD_SIZE +: BUFFER_WORD_SIZE] <= rd_data;
                        else
                            pe_datas[(int'(cnt) - 1) * BUFFER_WORD_SIZE +: BUFFER_WORD_SIZE] <= rd_data;
                    end
                    if (cnt == LOAD_END) begin
                        cnt <= '0;
                        if (state == LOAD_W) begin
                            state   <= LOAD_D;
                            rd_en   <= 1'b1;
                            rd_addr <= tile_addr(d_base, t, W);
                        end else begin
                            state      <= ARM;
                            pe_load_en <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        rd_en   <= (cnt < LAST_RD);
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                end
                ARM: begin
                    pe_load_en <= 1'b0;
                    pe_compute <= 1'b1;
                    state      <= COMPUTE;
                end
                COMPUTE: if (pe_done) begin
                    snap       <= pe_results;
                    pe_compute <= 1'b0;
                    wr_valid   <= 1'b1;
                    wr_addr    <= tile_addr(r_base, t, ELEMS);
                    wr_data    <= pe_results[ACCUMULATOR_DATA_WIDTH-1:0];
                    cnt        <= '0;
                    state      <= WRITEBACK;
                end
                WRITEBACK: if (wr_ready) begin
                    if (cnt == LAST_EL) begin
                        wr_valid <= 1'b0;
                        t        <= next_t;
                        cnt      <= '0;
                        if (next_t == num_tiles) begin
                            state      <= FINISH;
                            batch_done <= 1'b1;
                        end else if (reuse_w) begin
                            state   <= LOAD_D;
                            rd_en   <= 1'b1;
                            rd_addr <= tile_addr(d_base, next_t, W);
                        end else begin
                            state   <= LOAD_W;
                            rd_en   <= 1'b1;
                            rd_addr <= tile_addr(w_base, next_t, W);
                        end
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        wr_data <= snap[(int'(cnt) + 1) * ACCUMULATOR_DATA_WIDTH +: ACCUMULATOR_DATA_WIDTH];
                    end
                end
                FINISH: begin
                    batch_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PE_TILE_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst || (cmd_valid && cmd_ready))
            perf_q <= '0;
        else if (busy && (perf_q != '1))
            perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// tb/tb_pe_tile_scheduler.sv - randomized bench with buffer/controller models and a transaction scoreboard
module tb_pe_tile_scheduler;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_num_tiles = '0;
    logic          cmd_reuse_w = 1'b0;
    logic [11:0]   cmd_w_base = '0, cmd_d_base = '0, cmd_r_base = '0;
    logic          rd_en;
    logic [11:0]   rd_addr;
    logic [15:0]   rd_data = '0;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [11:0]   wr_addr;
    logic [15:0]   wr_data;
    logic          pe_load_en, pe_compute;
    logic          pe_done = 1'b0;
    logic [255:0]  pe_datas, pe_weights;
    logic [1023:0] pe_results = '0;
    logic          busy, batch_done;
    logic [31:0]   perf_cycles;

    always #5 clk = ~clk;

    pe_tile_scheduler dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_tiles(cmd_num_tiles),
        .cmd_reuse_w(cmd_reuse_w), .cmd_w_base(cmd_w_base), .cmd_d_base(cmd_d_base),
        .cmd_r_base(cmd_r_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .pe_load_en(pe_load_en), .pe_compute(pe_compute), .pe_done(pe_done),
        .pe_datas(pe_datas), .pe_weights(pe_weights), .pe_results(pe_results),
        .busy(busy), .batch_done(batch_done), .perf_cycles(perf_cycles)
    );

    logic [15:0]  mem [4096];
    int           vectors = 0, miscompares = 0;
    logic [11:0]  exp_rd[$], exp_wa[$];
    logic [15:0]  exp_wd[$];
    logic [255:0] exp_lw[$], exp_ld[$];
    int           n_reads = 0, n_writes = 0, n_loads = 0, n_acc = 0;
    logic [11:0]  first_raddr = '0, last_waddr = '0;
    logic [15:0]  first_wdata = '0;
    logic [255:0] last_lw = '0;
    int           wr_mode = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input logic [255:0] val);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event, value %0h", name, val);
    endtask

    function automatic int nib(input logic [15:0] w, input int j);
        int v;
        v = int'((w >> (4 * j)) & 16'hF);
        return (v >= 8) ? v - 16 : v;
    endfunction

    function automatic logic [15:0] mm(input int w[64], input int d[64], input int i);
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) s += w[(i / 8) * 8 + k] * d[k * 8 + i % 8];
        return 16'(s);
    endfunction

    function automatic logic [255:0] pack(input int e[64]);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[i * 4 +: 4] = 4'(e[i]);
        return v;
    endfunction

    // Expected traffic for a whole batch, straight from the buffer contents.
    task automatic model(input int n, input bit reuse, input logic [11:0] wb, input logic [11:0] db,
                         input logic [11:0] rb);
        int we[64];
        int de[64];
        for (int e = 0; e < 64; e++) begin we[e] = 0; de[e] = 0; end
        for (int t = 0; t < n; t++) begin
            if (!reuse || t == 0) begin
                for (int k = 0; k < 16; k++) exp_rd.push_back(12'(wb + t * 16 + k));
                for (int e = 0; e < 64; e++) we[e] = nib(mem[12'(wb + t * 16 + e / 4)], e % 4);
            end
            for (int k = 0; k < 16; k++) exp_rd.push_back(12'(db + t * 16 + k));
            for (int e = 0; e < 64; e++) de[e] = nib(mem[12'(db + t * 16 + e / 4)], e % 4);
            exp_lw.push_back(pack(we));
            exp_ld.push_back(pack(de));
            for (int i = 0; i < 64; i++) begin
                exp_wa.push_back(12'(rb + t * 64 + i));
                exp_wd.push_back(mm(we, de, i));
            end
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [11:0] prev_wa = '0;
    logic [15:0] prev_wd = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) n_acc++;
            chk("ready_vs_busy", cmd_ready, !busy);
            if (rd_en) begin
                chk("rd_wr_exclusive", wr_valid, 0);
                if (n_reads == 0) first_raddr = rd_addr;
                if (exp_rd.size() == 0) bad("rd_unexpected", rd_addr);
                else chk("rd_addr", rd_addr, exp_rd.pop_front());
                n_reads++;
            end
            if (prev_stall) begin
                chk("wr_hold_valid", wr_valid, 1);
                if (wr_valid) begin
                    chk("wr_hold_addr", wr_addr, prev_wa);
                    chk("wr_hold_data", wr_data, prev_wd);
                end
            end
            if (wr_valid && wr_ready) begin
                if (exp_wa.size() == 0) bad("wr_unexpected", wr_addr);
                else begin
                    chk("wr_addr", wr_addr, exp_wa.pop_front());
                    chk("wr_data", wr_data, exp_wd.pop_front());
                end
                if (n_writes == 0) first_wdata = wr_data;
                last_waddr = wr_addr;
                n_writes++;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_wa    = wr_addr;
            prev_wd    = wr_data;
            if (pe_load_en) begin
                last_lw = pe_weights;
                n_loads++;
                if (exp_lw.size() == 0) bad("load_unexpected", pe_weights);
                else begin
                    chk("load_weights", pe_weights, exp_lw.pop_front());
                    chk("load_datas", pe_datas, exp_ld.pop_front());
                end
            end
        end
    end

    // Buffer read port, write backpressure and PE controller, all driven just after the edge.
    initial begin
        logic        pen;
        logic [11:0] pad;
        int          ph;
        int          lat;
        int          we[64];
        int          de[64];
        pen = 1'b0; pad = '0; ph = 0; lat = -1;
        forever begin
            @(posedge clk); #1;
            rd_data = pen ? mem[pad] : 16'h0;
            pen = rd_en;
            pad = rd_addr;
            case (wr_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            pe_done = 1'b0;
            if (rst || !pe_compute) lat = -1;
            else begin
                if (lat == -1) begin
                    lat = int'($urandom_range(0, 12));
                    for (int e = 0; e < 64; e++) begin
                        we[e] = nib({12'h0, pe_weights[e * 4 +: 4]}, 0);
                        de[e] = nib({12'h0, pe_datas[e * 4 +: 4]}, 0);
                    end
                    for (int i = 0; i < 64; i++) pe_results[i * 16 +: 16] = mm(we, de, i);
                end else if (lat > 0) lat--;
                if (lat == 0) begin
                    pe_done = 1'b1;
                    lat = -2;
                end
            end
        end
    end

    task automatic run(input int n, input bit reuse, input logic [11:0] wb, input logic [11:0] db,
                       input logic [11:0] rb, input bit hold, input bit abort);
        int k;
        int acc0;
        model(n, reuse, wb, db, rb);
        n_reads = 0; n_writes = 0; n_loads = 0; acc0 = n_acc;
        k = 0;
        while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
        cmd_num_tiles = 8'(n); cmd_reuse_w = reuse;
        cmd_w_base = wb; cmd_d_base = db; cmd_r_base = rb;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        if (abort) begin
            k = 0;
            while (!pe_compute && k < 200) begin @(posedge clk); #1; k++; end
            if (!pe_compute) bad("abort_wait_compute_timeout", k);
            repeat (3) begin @(posedge clk); #1; end
            rst = 1'b1;
            exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_lw.delete(); exp_ld.delete();
            @(posedge clk); #1;
            chk("abort_pe_compute", pe_compute, 0);
            chk("abort_busy", busy, 0);
            chk("abort_cmd_ready", cmd_ready, 1);
            chk("abort_perf_cycles", perf_cycles, 0);
            rst = 1'b0;
            repeat (30) begin @(posedge clk); #1; end
            chk("abort_no_batch_done", batch_done, 0);
        end else begin
            k = 0;
            while (!batch_done && k < 30000) begin @(posedge clk); #1; k++; end
            cmd_valid = 1'b0;
            if (!batch_done) bad("batch_done_timeout", k);
            if (n == 0) chk("zero_tiles_latency_lt2", k < 2, 1);
            @(posedge clk); #1;
            chk("batch_done_one_cycle", batch_done, 0);
`ifdef PE_TILE_SCHED_PERF_EN
            chk("perf_cycles", perf_cycles, 32'(k + 1));
`else
            chk("perf_tied_off", perf_cycles, 0);
`endif
            chk("accepts", n_acc - acc0, 1);
            chk("rd_left", exp_rd.size(), 0);
            chk("wr_left", exp_wa.size(), 0);
            chk("load_left", exp_lw.size(), 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_wr_valid", wr_valid, 0);
        chk("reset_pe_compute", pe_compute, 0);
        chk("reset_pe_load_en", pe_load_en, 0);
        chk("reset_batch_done", batch_done, 0);
        chk("reset_pe_weights", pe_weights, 0);
        chk("reset_pe_datas", pe_datas, 0);
        chk("reset_perf_cycles", perf_cycles, 0);

        // Single tile: weights +1, data +2, every result is 8*1*2 = 16.
        for (int i = 0; i < 16; i++) begin mem[i] = 16'h1111; mem[16 + i] = 16'h2222; end
        run(1, 0, 12'h000, 12'h010, 12'h100, 0, 0);
        chk("single_reads", n_reads, 32);
        chk("single_first_raddr", first_raddr, 12'h000);
        chk("single_loads", n_loads, 1);
        chk("single_writes", n_writes, 64);
        chk("single_first_wdata", first_wdata, 16'd16);
        chk("single_last_waddr", last_waddr, 12'h13F);

        // Lane unpacking.
        mem[12'h200] = 16'h8F31;
        run(1, 0, 12'h200, 12'h300, 12'h400, 0, 0);
        chk("lane0", last_lw[3:0], 4'h1);
        chk("lane1", last_lw[7:4], 4'h3);
        chk("lane2", last_lw[11:8], 4'hF);
        chk("lane3", last_lw[15:12], 4'h8);

        run(3, 1, 12'h040, 12'h080, 12'h500, 0, 0);
        chk("reuse_reads", n_reads, 64);
        chk("reuse_loads", n_loads, 3);
        chk("reuse_writes", n_writes, 192);
        chk("reuse_last_waddr", last_waddr, 12'h5BF);

        wr_mode = 1;
        run(1, 0, 12'h600, 12'h610, 12'h700, 0, 0);
        chk("bp_writes", n_writes, 64);
        wr_mode = 0;

        run(0, 0, 12'h000, 12'h000, 12'h000, 0, 0);
        chk("zero_reads", n_reads, 0);
        chk("zero_writes", n_writes, 0);

        run(2, 0, 12'h120, 12'h160, 12'h800, 1, 0);
        chk("hold_writes", n_writes, 128);

        run(2, 0, 12'h220, 12'h260, 12'h900, 0, 1);
        run(1, 0, 12'h020, 12'h030, 12'hA00, 0, 0);
        chk("post_abort_writes", n_writes, 64);

        // Randomized batches, including bases near the top to exercise wrap.
        for (int r = 0; r < 6; r++) begin
            wr_mode = int'($urandom_range(0, 2));
            run(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom),
                (r == 0) ? 12'hFC0 : 12'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
